// File: rtl/des_pkg.sv
// Shared types and constants for the table-driven permutation engine.
// Bits are numbered [W:1]; table entries are 1-based source bit indices.
package des_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUILD,
    DONE
  } state_t;

  localparam int unsigned DES_P [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25
  };

  function automatic logic [32:1] des_p_apply(
    input logic [32:1] d
  );
    logic [32:1] r;
    r = '0;
    for (int i = 1; i <= 32; i++) begin
      r[i] = d[DES_P[i-1]];
    end
    return r;
  endfunction

endpackage

// File: rtl/perm_engine_builder.sv
// Sequential inverse-table rebuild: one forward entry per cycle,
// tracking which source bits were seen to detect a non-bijection.
module perm_inv_builder #(
  parameter int W     = 32,
  parameter int IDX_W = $clog2(W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             active,
  input  logic [IDX_W-1:0] ent,
  output logic [IDX_W-1:0] k,
  output logic             done,
  output logic             dup
);

  logic [W:1] seen;

  assign done = active && (k == IDX_W'(W));

  always_ff @(posedge clk) begin
    if (!rst_n || start) begin
      k    <= IDX_W'(1);
      seen <= '0;
      dup  <= 1'b0;
    end else if (active) begin
      if (seen[ent]) begin
        dup <= 1'b1;
      end
      seen[ent] <= 1'b1;
      if (!done) begin
        k <= k + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/perm_engine.sv
// Handshaked W-bit permutation through a loadable table, forward or
// inverse, with a registered result and a sequential inverse rebuild.
import des_pkg::*;

module perm_engine #(
  parameter int W           = 32,
  parameter int IDX_W       = $clog2(W + 1),
  parameter bit DES_DEFAULT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W:1]       in_data,
  input  logic             in_inv,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W:1]       out_data,
  output logic             out_err,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [IDX_W-1:0] cfg_data,
  input  logic             cfg_commit,
  output logic             busy,
  output logic             inv_ok,
  output logic             cfg_err
);

  function automatic logic [IDX_W-1:0] dflt(input int i);
    if (DES_DEFAULT && W == 32) begin
      return IDX_W'(DES_P[i-1]);
    end
    return IDX_W'(i);
  endfunction

  function automatic logic [IDX_W-1:0] dflt_inv(input int i);
    logic [IDX_W-1:0] r;
    r = IDX_W'(i);
    for (int j = 1; j <= W; j++) begin
      if (dflt(j) == IDX_W'(i)) begin
        r = IDX_W'(j);
      end
    end
    return r;
  endfunction

  logic [IDX_W-1:0] fwd [1:W];
  logic [IDX_W-1:0] inv [1:W];
  state_t           state;
  state_t           nxt;
  logic [IDX_W-1:0] k;
  logic [IDX_W-1:0] ent;
  logic             done;
  logic             dup;
  logic             building;
  logic             start;
  logic             xfer;
  logic             addr_ok;
  logic             data_ok;
  logic             wr_ok;
  logic [W:1]       fwd_res;
  logic [W:1]       inv_res;

  assign busy     = (state != IDLE);
  assign building = (state == BUILD);
  assign in_ready = !busy && (!out_valid || out_ready);
  assign xfer     = in_valid && in_ready;
  assign start    = (state == IDLE) && cfg_commit;
  assign addr_ok  = (cfg_addr != '0) && (cfg_addr <= IDX_W'(W));
  assign data_ok  = (cfg_data != '0) && (cfg_data <= IDX_W'(W));
  assign wr_ok    = cfg_we && !busy && addr_ok && data_ok;
  assign ent      = fwd[k];

  for (genvar i = 1; i <= W; i++) begin : g_tab
    logic [IDX_W-1:0] f_q;
    logic [IDX_W-1:0] i_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        f_q <= dflt(i);
      end else if (wr_ok && cfg_addr == IDX_W'(i)) begin
        f_q <= cfg_data;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        i_q <= dflt_inv(i);
      end else if (building && ent == IDX_W'(i)) begin
        i_q <= k;
      end
    end

    assign fwd[i] = f_q;
    assign inv[i] = i_q;
  end

  perm_inv_builder #(
    .W     (W),
    .IDX_W (IDX_W)
  ) u_builder (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .active (building),
    .ent    (ent),
    .k      (k),
    .done   (done),
    .dup    (dup)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (cfg_commit) nxt = BUILD;
      BUILD:   if (done) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    fwd_res = '0;
    inv_res = '0;
    for (int i = 1; i <= W; i++) begin
      fwd_res[i] = in_data[fwd[i]];
      inv_res[i] = in_data[inv[i]];
    end
  end

  // inv_ok stays low from any table change until a clean rebuild completes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inv_ok  <= 1'b1;
      cfg_err <= 1'b0;
    end else begin
      if (state == DONE) begin
        inv_ok <= !dup;
      end else if (start || wr_ok) begin
        inv_ok <= 1'b0;
      end
      if (busy && (cfg_we || cfg_commit)) begin
        cfg_err <= 1'b1;
      end
      if (!busy && cfg_we && !(addr_ok && data_ok)) begin
        cfg_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_err   <= in_inv && !inv_ok;
      if (!in_inv) begin
        out_data <= fwd_res;
      end else if (inv_ok) begin
        out_data <= inv_res;
      end else begin
        out_data <= '0;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/perm_engine.md
Name: perm_engine

Overview:
- Parametrised, handshaked successor to the fixed 32-bit DES P permutation.
- Permutes a W-bit word through a runtime-loadable table in either forward or inverse direction, with one registered pipeline stage and valid/ready flow control.
- The inverse table is rebuilt sequentially after every table commit, and the rebuild checks that the table is a bijection.
- Sits between the S-box output and the round XOR. It is also reusable for IP, IP⁻¹ and PC tables of equal width.

Parameters:
- W, 32, word width; bits numbered [W:1], index W is the MSB.
- IDX_W, $clog2(W+1), width of a 1-based table entry.
- DES_DEFAULT, 1, when 1 and W==32 the reset table is DES P; otherwise the reset table is identity.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  engine accepts the input word.
- in_data  in  W [W:1]  word to permute.
- in_inv  in  1  0 = forward, 1 = inverse; sampled with in_data.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  W [W:1]  permuted word.
- out_err  out  1  result invalid (inverse requested while inv_ok=0).
- cfg_we  in  1  table entry write strobe.
- cfg_addr  in  IDX_W  destination bit, 1..W.
- cfg_data  in  IDX_W  source bit, 1..W.
- cfg_commit  in  1  start the inverse-table rebuild.
- busy  out  1  rebuild in progress.
- inv_ok  out  1  inverse table valid (forward table is a bijection).
- cfg_err  out  1  sticky: out-of-range cfg write, or cfg write/commit while busy.

Behaviour:
- Forward map: out_data[i] = in_data[fwd[i]] for i = 1..W.
- Inverse map: out_data[i] = in_data[inv[i]], where inv[fwd[i]] = i.
- Reset (rst_n=0 at a rising edge):
  - fwd loaded with the default table; inv loaded with its inverse; inv_ok=1.
  - out_valid=0, out_data=0, out_err=0, busy=0, cfg_err=0, FSM=IDLE.
  - Reset during BUILD aborts the rebuild and restores the default tables.
- Handshake:
  - in_ready = !busy && (!out_valid || out_ready).
  - A transfer occurs when in_valid && in_ready. The result is registered, so out_valid rises the next cycle: latency 1, throughput 1 word per cycle.
  - While out_valid && !out_ready, out_data, out_err and out_valid hold stable.
  - out_valid drops after the accepting cycle unless a new word transfers in the same cycle.
- Inverse while inv_ok=0: the word is accepted, out_data=0 and out_err=1 for that result. Forward results always have out_err=0.
- Config writes:
  - Accepted only when busy=0.
  - cfg_addr or cfg_data outside 1..W: write dropped, cfg_err set.
  - A valid write updates fwd[cfg_addr] and clears inv_ok on the next edge.
  - Forward transfers in the write cycle use the old entry; transfers from the next cycle use the new one.
  - cfg_we or cfg_commit while busy: ignored, cfg_err set.
- FSM:
  - IDLE: cfg_commit (with busy=0) goes to BUILD, clears counter k=1, seen bitmap and dup flag. A cfg_we in the same cycle is applied before the build reads fwd.
  - BUILD: one entry per cycle.
    - Write inv[fwd[k]] = k.
    - If seen[fwd[k]] is already set, set dup; then set seen[fwd[k]].
    - k increments; when k==W, go to DONE.
  - DONE: inv_ok = !dup; return to IDLE.
- BUILD timing: busy=1 for exactly W+1 cycles after the commit edge, and in_ready=0 for that whole time. An already-registered result still drains.
- cfg_err clears only on reset.

Decomposition:
- Shared package des_pkg holds:
  - DES_P table constant (32 entries, 1-based, same order as the FIPS 46-3 P table).
  - FSM state typedef {IDLE, BUILD, DONE}.
  - Helper function that applies a table to a word.
- One natural sub-module, perm_inv_builder: the BUILD counter, seen bitmap and dup logic, writing inv entries and reporting done/dup.
- Datapath muxes and handshake stay in perm_engine.

Test Plan:
- Default forward: after reset, in_data=32'h0000_0001, in_inv=0 → next cycle out_valid=1, out_data=32'h0000_0100 (out[9]=in[1]), out_err=0.
- Inverse round-trip: in_data=32'h0000_0100, in_inv=1 → out_data=32'h0000_0001. Then 1000 random words, forward then inverse → each returns the original word.
- Backpressure: out_ready=0 for 5 cycles with in_valid=1 → in_ready=0 after the first transfer, out_data held. out_ready=1 → one word per cycle, no loss or duplication.
- Bad table: write addr 2 = 1 (duplicates entry 9), commit → busy high for 33 cycles, in_ready=0, then inv_ok=0. An inverse request then gives out_err=1, out_data=0. Rewrite addr 2 = 7, commit → inv_ok=1.
- Config errors: cfg_addr=0 → cfg_err=1, table unchanged. cfg_we during BUILD → cfg_err=1, write ignored.
- Reset mid-BUILD: assert rst_n=0 at cycle 10 of the build → busy=0, inv_ok=1, DES P default restored, first result after reset matches the first scenario.
